image_frame_buffer: RTL and testbench

- 64x64 RGB888 frame store. It is the responder side of the row/col pixel-access interface that the image processing FSM drives.
  - The processor side presents row/col, receives the pixel combinationally, and writes results back with a write enable.
- Two bench/system streaming ports:
  - a raster load port that fills the frame;
  - a raster dump port that drains it.
- Access is arbitrated by an internal FSM, so processor writes never collide with streaming.

---
 rtl/image_frame_buffer.sv | 130 +++++++++++++
 tb/tb_image_frame_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_buffer.sv
// image_frame_buffer: ROWS x COLS pixel store.
// The processor side reads combinationally at [row][col] and may write while idle.
// A raster load stream fills the frame and a raster dump stream drains it.
// A three-state FSM owns the shared address counter and the write port.
module image_frame_buffer #(
  parameter int ROWS  = 64,
  parameter int COLS  = 64,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       row,
  input  logic [5:0]       col,
  output logic [PIX_W-1:0] in_pix,
  input  logic             out_we,
  input  logic [PIX_W-1:0] out_pix,
  output logic             busy,
  input  logic             load_start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pix,
  output logic             load_done,
  input  logic             dump_start,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_pix,
  output logic             m_last
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int AW    = RW + CW;
  localparam int DEPTH = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, LOAD, DUMP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              load_done_q, load_done_d;

  logic [PIX_W-1:0]  mem [DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [AW-1:0]     proc_addr;
  logic              addr_last;

  // Row-major linear address: row*COLS + col, with col in the low bits.
  assign proc_addr = {row[RW-1:0], col[CW-1:0]};
  assign addr_last = (addr_q == AW'(DEPTH - 1));

  // Asynchronous reads: the processor port always sees the stored value,
  // so a same-cycle write to the same address still reads the old pixel.
  assign in_pix    = mem[proc_addr];
  assign m_pix     = mem[addr_q];
  assign busy      = (state_q != IDLE);
  assign load_done = load_done_q;

  // State, address counter and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      load_done_q <= load_done_d;
    end
  end

  // Next-state, stream handshakes and arbitration of the single write port.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    load_done_d = 1'b0;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = proc_addr;
    mem_wdata   = out_pix;
    case (state_q)
      IDLE: begin
        mem_we = out_we;
        // Load has priority; a coincident dump request is dropped.
        if (load_start) begin
          state_d = LOAD;
          addr_d  = '0;
        end else if (dump_start) begin
          state_d = DUMP;
          addr_d  = '0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          mem_we    = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = s_pix;
          addr_d    = addr_q + 1'b1;
          if (addr_last) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
            addr_d      = '0;
          end
        end
      end
      DUMP: begin
        m_valid = 1'b1;
        m_last  = addr_last;
        if (m_ready) begin
          addr_d = addr_q + 1'b1;
          if (addr_last) begin
            state_d = IDLE;
            addr_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel storage; never cleared, and no writes land during reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_image_frame_buffer.sv
// Scoreboard bench for image_frame_buffer: the driver keeps a plain array
// image of the frame and queues expected dump beats / load_done cycles;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_image_frame_buffer;

  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  row, col;
  logic [23:0] in_pix;
  logic        out_we;
  logic [23:0] out_pix;
  logic        busy;
  logic        load_start, s_valid, s_ready;
  logic [23:0] s_pix;
  logic        load_done;
  logic        dump_start, m_valid, m_ready, m_last;
  logic [23:0] m_pix;

  image_frame_buffer dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .in_pix(in_pix),
    .out_we(out_we), .out_pix(out_pix), .busy(busy),
    .load_start(load_start), .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix),
    .load_done(load_done), .dump_start(dump_start), .m_valid(m_valid),
    .m_ready(m_ready), .m_pix(m_pix), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          mon_en = 1'b0;
  logic [23:0] ref_mem [N];
  logic [24:0] exp_q [$];   // {last, pix} per expected dump beat
  int          done_q [$];  // cycle in which load_done must be high

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: consumes expectations as the DUT presents outputs.
  bit          held_v = 1'b0;
  logic [24:0] held;
  logic [24:0] e;
  bit          ld_exp;
  always @(negedge clk) begin
    if (mon_en) begin
      ld_exp = (done_q.size() != 0);
      chk("load_done", {31'b0, load_done}, {31'b0, ld_exp});
      if (ld_exp) void'(done_q.pop_front());
      if (m_valid && held_v) chk("m_stall_hold", {7'b0, m_last, m_pix}, {7'b0, held});
      if (m_valid && m_ready) begin
        chk("dump_beat_pending", exp_q.size(), 32'(exp_q.size() != 0 ? exp_q.size() : 1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("dump_beat", {7'b0, m_last, m_pix}, {7'b0, e});
        end
      end
      if (!m_valid) chk("m_last_idle", {31'b0, m_last}, 32'd0);
      held_v = m_valid && !m_ready;
      held   = {m_last, m_pix};
    end
  end

  // Compare every address through the processor read port.
  task automatic check_all(input string nm);
    int errs = 0;
    int first = -1;
    for (int i = 0; i < N; i++) begin
      row = i[11:6];
      col = i[5:0];
      #1;
      if (in_pix !== ref_mem[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: %0d addresses differ, first at %0d got %h expected %h",
               nm, errs, first, dut.mem[first], ref_mem[first]);
    end
    @(posedge clk); #1;
  endtask

  // mode 0: {row,col,0} held valid; 1: random data with gaps; 2: random held.
  task automatic load_frame(input int mode, input int nbeats, input bit do_start);
    int n = 0;
    int guard = 0;
    int sr_bad = 0;
    bit v;
    logic [23:0] p;
    if (do_start) begin
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
    end
    while (n < nbeats && guard < 4 * N) begin
      v = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      p = (mode == 0) ? {n[11:6], n[5:0], 12'h000} : 24'($urandom);
      s_valid = v;
      s_pix   = p;
      if (!s_ready) sr_bad++;
      @(posedge clk); #1;
      guard++;
      if (v) begin
        ref_mem[n] = p;
        n++;
        if (n == N) done_q.push_back(cyc);
      end
    end
    s_valid = 1'b0;
    chk("load_beats", n, nbeats);
    chk("s_ready_held", sr_bad, 0);
  endtask

  // mode 0: m_ready high; 1: toggling; 2: random. poke drives a write and
  // a load_start mid-dump, both of which must be ignored.
  task automatic dump_frame(input int mode, input bit poke);
    int guard = 0;
    for (int i = 0; i < N; i++) exp_q.push_back({i == N - 1, ref_mem[i]});
    dump_start = 1'b1;
    m_ready    = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    while (exp_q.size() != 0 && guard < 4 * N) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = guard[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && (guard == 10 || guard == 11)) begin
        row = 6'd0; col = 6'd0; out_we = 1'b1; out_pix = 24'h123456;
        load_start = 1'b1;
      end else begin
        out_we = 1'b0;
        load_start = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_we = 1'b0;
    load_start = 1'b0;
    m_ready = 1'b1;
    chk("dump_complete", exp_q.size(), 0);
    chk("dump_busy_after", {31'b0, busy}, 32'd0);
    chk("dump_mvalid_after", {31'b0, m_valid}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; row = '0; col = '0; out_we = 1'b0; out_pix = '0;
    load_start = 1'b0; s_valid = 1'b0; s_pix = '0; dump_start = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_last", {31'b0, m_last}, 32'd0);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Full pattern load, valid held high.
    load_frame(0, N, 1'b1);
    chk("load_busy_after", {31'b0, busy}, 32'd0);
    row = 6'd5; col = 6'd9; #1;
    chk("pix_5_9", {8'b0, in_pix}, {8'b0, 6'd5, 6'd9, 12'h000});
    check_all("after_pattern_load");

    // Processor write in IDLE: old value same cycle, new value after edge.
    row = 6'd3; col = 6'd60; out_we = 1'b1; out_pix = 24'hABCDEF; #1;
    chk("proc_wr_old", {8'b0, in_pix}, {8'b0, ref_mem[3*64+60]});
    @(posedge clk); #1;
    out_we = 1'b0;
    ref_mem[3*64+60] = 24'hABCDEF;
    chk("proc_wr_new", {8'b0, in_pix}, 32'h00ABCDEF);
    check_all("after_proc_write");

    // Dump with m_ready toggling.
    dump_frame(1, 1'b0);

    // Coincident starts: load wins, no dump follows.
    load_start = 1'b1; dump_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0; dump_start = 1'b0;
    chk("both_s_ready", {31'b0, s_ready}, 32'd1);
    chk("both_m_valid", {31'b0, m_valid}, 32'd0);
    chk("both_busy", {31'b0, busy}, 32'd1);
    load_frame(1, N, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("no_dump_after_both", {31'b0, m_valid}, 32'd0);
    check_all("after_random_load");

    // Writes and load_start during a dump are ignored.
    dump_frame(2, 1'b1);
    row = 6'd0; col = 6'd0; #1;
    chk("pix_0_0_kept", {8'b0, in_pix}, {8'b0, ref_mem[0]});
    dump_frame(0, 1'b0);

    // Reset after 100 accepted load beats.
    load_frame(2, 100, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_s_ready", {31'b0, s_ready}, 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_all("after_mid_reset");
    dump_frame(0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("load_done_q_drained", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
